// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_rx_cfg : UART receiver, configurable width/parity/stop bits, valid/ready output
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote per bit.  Revision 1.0
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int         CYCLE       = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] C_LAST     = 16'(CYCLE - 1);
  localparam logic [15:0] C_MID      = 16'(CYCLE / 2 - 1);
  localparam logic [3:0] C_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] C_STOP_LAST = 4'(STOP_BITS - 1);

  if (CYCLE < 8 || CYCLE >= 65536 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_cfg: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state, state_nxt;
  logic                   s0, s1, s2;
  logic                   fall, sample, bit_end, bit_val, done;
  logic [15:0]            cycle_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bad, stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s0 <= rx_pin;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign fall    = s2 & ~s1;
  assign bit_end = (cycle_cnt == C_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic v0, v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (cycle_cnt == 16'(CYCLE / 2 - 2)) v0 <= s1;
      if (cycle_cnt == C_MID)              v1 <= s1;
    end
  end

  // third vote is the live s1, so the decision lands one clock after the nominal sample
  assign sample  = (cycle_cnt == 16'(CYCLE / 2));
  assign bit_val = (v0 & v1) | (v0 & s1) | (v1 & s1);
`else
  assign sample  = (cycle_cnt == C_MID);
  assign bit_val = s1;
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START: begin
        if (sample && bit_val) state_nxt = S_IDLE;
        else if (bit_end)      state_nxt = S_DATA;
      end
      S_DATA:   if (bit_end && bit_cnt == C_DATA_LAST) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        // leave at the last stop sample so an immediately following start edge is caught
        if (sample && bit_cnt == C_STOP_LAST) begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cycle_cnt <= 16'd0;
      bit_cnt   <= 4'd0;
      shift     <= '0;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || bit_end) cycle_cnt <= 16'd0;
      else                               cycle_cnt <= cycle_cnt + 16'd1;
      if (state_nxt != state) bit_cnt <= 4'd0;
      else if (bit_end)       bit_cnt <= bit_cnt + 4'd1;
      if (state == S_DATA && sample) shift <= {bit_val, shift[DATA_BITS-1:1]};
      if (state == S_START) begin
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (state == S_PARITY && sample) par_bad  <= ((^shift) ^ bit_val) != (PARITY == 1);
      if (state == S_STOP && sample && !bit_val) stop_bad <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rx_data_valid || rx_data_ready) begin
          rx_data       <= shift;
          parity_err    <= par_bad;
          frame_err     <= stop_bad | ~bit_val;
          rx_data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
